// File: rtl/program_memory.sv
// Loadable instruction store: a streaming load port fills the array, and a
// one-cycle-latency fetch port returns NOP_WORD for addresses past prog_len.
module program_memory #(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(4'b0111)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  load_busy,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic [ADDR_WIDTH:0]   prog_len
);

  localparam int                DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     prog_len_q, prog_len_d;
  logic                    load_ready_q, load_ready_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0]   fetch_data_q, fetch_data_d;
  logic                    accept;
  logic                    fetch_hit;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // prog_len doubles as the write pointer: both restart at 0 and advance together.
  assign accept    = (state_q == LOAD) && load_valid && load_ready_q;
  assign fetch_hit = ({1'b0, fetch_addr} < prog_len_q);

  always_comb begin
    state_d       = state_q;
    prog_len_d    = prog_len_q;
    fetch_valid_d = 1'b0;
    fetch_data_d  = fetch_data_q;
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = fetch_hit ? mem[fetch_addr] : NOP_WORD;
        end
        if (load_start) begin
          state_d    = LOAD;
          prog_len_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          prog_len_d = prog_len_q + LEN_ONE;
          if (load_last || (prog_len_q == LAST_IDX)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    load_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      prog_len_q    <= '0;
      load_ready_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= NOP_WORD;
    end else begin
      state_q       <= state_d;
      prog_len_q    <= prog_len_d;
      load_ready_q  <= load_ready_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q  <= fetch_data_d;
    end
  end

  // Array contents survive reset; prog_len = 0 alone masks them as NOPs.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[prog_len_q[ADDR_WIDTH-1:0]] <= load_data;
    end
  end

  assign load_ready  = load_ready_q;
  assign load_busy   = (state_q == LOAD);
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: a behavioural model predicts each fetch
// result when the request is driven; the monitor pops and compares on output.
module tb_program_memory;

  localparam int         DW  = 4;
  localparam int         AW  = 4;
  localparam logic [3:0] NOP = 4'b0111;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start, load_valid, load_last, fetch_req;
  logic [DW-1:0] load_data;
  logic [AW-1:0] fetch_addr;
  logic          load_ready, load_busy, fetch_valid;
  logic [DW-1:0] fetch_data;
  logic [AW:0]   prog_len;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb_q [$];
  logic          exp_req = 1'b0;

  logic          m_load;
  logic [AW:0]   m_len;
  logic [DW-1:0] m_mem [16];

  program_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_busy(load_busy),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check pre-edge outputs, advance model.
  task automatic step(input logic ls, input logic lv, input logic [3:0] ld,
                      input logic ll, input logic fr, input logic [3:0] fa);
    @(negedge clk);
    load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
    fetch_req = fr; fetch_addr = fa;
    check("load_ready", {31'd0, load_ready}, {31'd0, m_load});
    check("load_busy",  {31'd0, load_busy},  {31'd0, m_load});
    check("prog_len",   {27'd0, prog_len},   {27'd0, m_len});
    exp_req = fr && !m_load;
    if (exp_req) sb_q.push_back(({1'b0, fa} < m_len) ? m_mem[fa] : NOP);
    if (m_load) begin
      if (lv) begin
        m_mem[m_len[3:0]] = ld;
        m_len = m_len + 5'd1;
        if (ll || m_len == 5'd16) m_load = 1'b0;
      end
    end else if (ls) begin
      m_load = 1'b1;
      m_len  = '0;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic fetch(input logic [3:0] a);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, a);
  endtask

  always begin
    logic pend;
    logic [DW-1:0] e;
    @(posedge clk);
    pend = exp_req;
    #1;
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, pend});
    if (fetch_valid && pend) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("fetch_data", {28'd0, fetch_data}, {28'd0, e});
      end
    end
  end

  logic [3:0] prog8 [8] = '{4'b0000, 4'b0001, 4'b1010, 4'b0010,
                            4'b1011, 4'b0010, 4'b1110, 4'b0010};

  initial begin
    reset = 1'b1;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    m_load = 1'b0; m_len = '0;
    #1;
    check("rst_fetch_data", {28'd0, fetch_data}, {28'd0, NOP});
    check("rst_prog_len", {27'd0, prog_len}, 32'd0);
    check("rst_busy", {31'd0, load_busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) fetch(4'(i));
    idle();

    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, prog8[i], (i == 7), 1'b0, 4'h0);
    idle();
    check("len_after_8", {27'd0, prog_len}, 32'd8);
    fetch(4'd2); idle();
    fetch(4'd7); idle();
    fetch(4'd8); idle();
    fetch(4'd0); fetch(4'd1); fetch(4'd2); idle();

    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'd3);
    fetch(4'd0); fetch(4'd1);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 4'h0);
    idle();
    check("len_after_16", {27'd0, prog_len}, 32'd16);
    fetch(4'd0); fetch(4'd15); fetch(4'd7); idle();

    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'(i + 9), 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    load_valid = 1'b0; fetch_req = 1'b0; exp_req = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_prog_len", {27'd0, prog_len}, 32'd0);
    check("midrst_busy", {31'd0, load_busy}, 32'd0);
    check("midrst_ready", {31'd0, load_ready}, 32'd0);
    m_load = 1'b0; m_len = '0;
    @(negedge clk);
    reset = 1'b0;
    fetch(4'd1); idle();
    idle();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
